spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 145 ++++++++++++++
 tb/tb_spi_master.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI mode-0 master: byte-streamed transaction of 1..15 bytes under one SS assertion, MSB first.
// Each bit costs 2*HALF_DIV clk; between bytes the master parks in LOAD (sck=0, ss=0) until tx_valid.
module spi_master #(
    parameter int HALF_DIV = 25,
    parameter int CS_GAP   = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] nbytes,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       done,
    output logic       sck,
    output logic       ss,
    output logic       mosi,
    input  logic       miso
);

    localparam int CW = 16;
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(CS_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOAD,
        S_LOW,
        S_HIGH,
        S_HOLD
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [3:0]      r_bit;
    logic [3:0]      r_bytes;
    logic [7:0]      r_tx;
    logic [7:0]      r_rx;
    logic [7:0]      r_rx_data;
    logic            r_rx_valid;
    logic            r_done;
    logic            r_mosi;
    logic            w_half_end;
    logic            w_gap_end;
    logic            w_last_bit;

    assign w_half_end = (r_cnt == HALF_LAST);
    assign w_gap_end  = (r_cnt == GAP_LAST);
    assign w_last_bit = (r_bit == 4'd7);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start && (nbytes != 4'd0)) w_next = S_SETUP;
            S_SETUP: if (w_gap_end) w_next = S_LOAD;
            S_LOAD:  if (tx_valid) w_next = S_LOW;
            S_LOW:   if (w_half_end) w_next = S_HIGH;
            S_HIGH: begin
                if (w_half_end) begin
                    if (!w_last_bit)            w_next = S_LOW;
                    else if (r_bytes > 4'd1)    w_next = S_LOAD;
                    else                        w_next = S_HOLD;
                end
            end
            S_HOLD:  if (w_gap_end) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_bytes    <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_done     <= 1'b0;
            r_mosi     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_rx_valid <= 1'b0;
            r_done     <= 1'b0;
            // Phase counter restarts on every state change and idles at 0 while waiting.
            if ((w_next != r_state) || (r_state == S_IDLE) || (r_state == S_LOAD))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CW'(1);

            case (r_state)
                S_IDLE: begin
                    r_bit <= '0;
                    if (w_next == S_SETUP) r_bytes <= nbytes;
                end
                S_LOAD: begin
                    if (tx_valid) begin
                        r_tx   <= tx_data;
                        r_mosi <= tx_data[7];
                    end
                end
                S_LOW: begin
                    if (w_half_end) r_rx <= {r_rx[6:0], miso};
                end
                S_HIGH: begin
                    if (w_half_end) begin
                        if (!w_last_bit) begin
                            r_bit  <= r_bit + 4'd1;
                            r_tx   <= {r_tx[6:0], 1'b0};
                            r_mosi <= r_tx[6];
                        end else begin
                            r_bit      <= '0;
                            r_rx_data  <= r_rx;
                            r_rx_valid <= 1'b1;
                            r_bytes    <= r_bytes - 4'd1;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_gap_end) begin
                        r_done <= 1'b1;
                        r_mosi <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx_ready = (r_state == S_LOAD);
    assign busy     = (r_state != S_IDLE);
    assign sck      = (r_state == S_HIGH);
    assign ss       = (r_state == S_IDLE);
    assign mosi     = r_mosi;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign done     = r_done;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: directed transactions against a bit-level scoreboard and a mode-0 slave.
module tb_spi_master;

    localparam int HALF_DIV = 25;
    localparam int CS_GAP   = 25;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] nbytes;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       done;
    logic       sck;
    logic       ss;
    logic       mosi;
    logic       miso;

    logic       loopback;
    logic       s_miso;
    assign miso = loopback ? mosi : s_miso;

    spi_master #(.HALF_DIV(HALF_DIV), .CS_GAP(CS_GAP)) dut (
        .clk(clk), .rst(rst), .start(start), .nbytes(nbytes),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
        .sck(sck), .ss(ss), .mosi(mosi), .miso(miso)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic fail(input string name, input int act, input int req);
        checks++;
        failures++;
        $display("FAIL %s actual=%0d required=%0d", name, act, req);
    endtask

    // Scoreboard: every SCK rise must present the next queued bit; every rx_valid the next queued byte.
    logic       exp_bits[$];
    logic [7:0] exp_rx[$];
    int         rx_cnt = 0, done_cnt = 0, ss_rise_cnt = 0, sck_rise_cnt = 0;
    int         rise_idx = 0;
    time        last_rise = 0;
    logic       prev_sck = 1'b0, prev_mosi = 1'b0, prev_ss = 1'b1;

    always @(negedge clk) begin
        if (!rst) begin
            exp_bits.delete();
            exp_rx.delete();
            rise_idx = 0;
        end else begin
            if (sck && !prev_sck) begin
                sck_rise_cnt++;
                check("mosi_stable_at_sck_rise", mosi, prev_mosi);
                if (exp_bits.size() == 0) fail("unexpected_sck_rise", sck_rise_cnt, 0);
                else check("mosi_bit", mosi, exp_bits.pop_front());
                if (rise_idx != 0) check("sck_period_ns", 32'($time - last_rise), 32'd1000);
                last_rise = $time;
                rise_idx  = (rise_idx == 7) ? 0 : rise_idx + 1;
            end
            if (rx_valid) begin
                rx_cnt++;
                if (exp_rx.size() == 0) fail("unexpected_rx_valid", rx_data, 0);
                else check("rx_data", rx_data, exp_rx.pop_front());
            end
            if (done) done_cnt++;
            if (ss && !prev_ss) ss_rise_cnt++;
            check("ss_high_iff_not_busy", ss, !busy);
            check("done_with_rx_valid", done & rx_valid, 0);
            if (tx_ready) check("load_sck_ss_low", {sck, ss}, 0);
        end
        prev_sck  = sck;
        prev_mosi = mosi;
        prev_ss   = ss;
    end

    // Mode-0 slave: MSB ready on SS fall, next bit after each SCK fall.
    logic [7:0] slave_q[$];
    logic [7:0] s_sh = 8'h00;
    int         s_cnt = 0;
    logic       s_active = 1'b0;
    initial s_miso = 1'b0;

    always @(negedge ss or posedge ss or negedge sck) begin
        if (ss) begin
            s_active = 1'b0;
        end else if (!s_active) begin
            s_active = 1'b1;
            s_sh     = (slave_q.size() != 0) ? slave_q.pop_front() : 8'h00;
            s_cnt    = 0;
            s_miso   = s_sh[7];
        end else begin
            s_cnt++;
            if (s_cnt == 8) begin
                s_cnt = 0;
                s_sh  = (slave_q.size() != 0) ? slave_q.pop_front() : 8'h00;
            end else begin
                s_sh = {s_sh[6:0], 1'b0};
            end
            s_miso = s_sh[7];
        end
    end

    logic [7:0] txb[15];

    task automatic send_byte(input logic [7:0] b, input int stall);
        int   n  = 0;
        logic ok = 1'b1;
        while (!tx_ready && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!tx_ready) fail("tx_ready_timeout", n, 5000);
        if (stall > 0) begin
            repeat (stall) begin
                @(posedge clk); #1;
                if (!(tx_ready && !sck && !ss)) ok = 1'b0;
            end
            check("stall_ready_sck_ss", ok, 1);
        end
        for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
    endtask

    task automatic run_txn(input int n, input int stall_idx, input int stall_len, input logic poke);
        int d0 = done_cnt;
        int r0 = rx_cnt;
        int s0 = ss_rise_cnt;
        int k  = 0;
        @(posedge clk); #1;
        start  = 1'b1;
        nbytes = 4'(n);
        @(posedge clk); #1;
        start  = 1'b0;
        nbytes = 4'd0;
        if (poke) begin
            start  = 1'b1;
            nbytes = 4'd5;
            @(posedge clk); #1;
            start  = 1'b0;
            nbytes = 4'd0;
        end
        for (int i = 0; i < n; i++) send_byte(txb[i], (i == stall_idx) ? stall_len : 0);
        while (done_cnt == d0 && k < 20000) begin
            @(posedge clk);
            k++;
        end
        if (done_cnt == d0) fail("done_timeout", k, 20000);
        repeat (2) @(posedge clk);
        #1;
        check("done_pulses", done_cnt - d0, 1);
        check("rx_pulses", rx_cnt - r0, n);
        check("ss_rises", ss_rise_cnt - s0, 1);
        check("rx_queue_drained", exp_rx.size(), 0);
        check("mosi_queue_drained", exp_bits.size(), 0);
    endtask

    initial begin
        int   k;
        int   base;
        int   r0;
        int   d0;
        logic ok;
        rst = 1'b1; start = 1'b0; nbytes = 4'd0; tx_data = 8'h00; tx_valid = 1'b0; loopback = 1'b1;
        #3 rst = 1'b0;
        #2;
        check("reset_outputs", {sck, ss, mosi, tx_ready, rx_valid, busy, done}, 7'b0100000);
        check("reset_rx_data", rx_data, 8'h00);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Loopback of 0xA5.
        txb[0] = 8'hA5;
        exp_rx.push_back(8'hA5);
        run_txn(1, -1, 0, 1'b0);

        // Slave returns 3C C3 FF; a start during the transfer must be ignored.
        loopback = 1'b0;
        slave_q  = '{8'h3C, 8'hC3, 8'hFF};
        txb[0] = 8'hAA; txb[1] = 8'h55; txb[2] = 8'h00;
        exp_rx.push_back(8'h3C); exp_rx.push_back(8'hC3); exp_rx.push_back(8'hFF);
        run_txn(3, -1, 0, 1'b1);
        base = sck_rise_cnt;
        repeat (200) @(posedge clk);
        #1;
        check("no_extra_txn_busy", busy, 0);
        check("no_extra_txn_sck", sck_rise_cnt - base, 0);

        // 100-cycle stall before byte 2.
        loopback = 1'b1;
        txb[0] = 8'h5A; txb[1] = 8'hC3;
        exp_rx.push_back(8'h5A); exp_rx.push_back(8'hC3);
        run_txn(2, 1, 100, 1'b0);

        // nbytes=0 start is ignored.
        @(posedge clk); #1;
        start = 1'b1; nbytes = 4'd0;
        @(posedge clk); #1;
        start = 1'b0;
        ok = 1'b1;
        repeat (50) begin
            @(posedge clk); #1;
            if (busy || !ss) ok = 1'b0;
        end
        check("nbytes0_ignored", ok, 1);

        // Maximum 15-byte transaction.
        for (int i = 0; i < 15; i++) begin
            txb[i] = 8'(i * 37 + 1);
            exp_rx.push_back(8'(i * 37 + 1));
        end
        run_txn(15, -1, 0, 1'b0);

        // Reset after 4 SCK rises of a loopback byte.
        base = sck_rise_cnt;
        r0   = rx_cnt;
        d0   = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; nbytes = 4'd1;
        @(posedge clk); #1;
        start = 1'b0; nbytes = 4'd0;
        send_byte(8'h3E, 0);
        k = 0;
        while (sck_rise_cnt < base + 4 && k < 2000) begin
            @(posedge clk);
            k++;
        end
        if (sck_rise_cnt < base + 4) fail("abort_rise_timeout", sck_rise_cnt - base, 4);
        #107 rst = 1'b0;
        #1;
        check("abort_sck_ss_busy", {sck, ss, busy}, 3'b010);
        check("abort_pulses", {rx_valid, done}, 2'b00);
        check("abort_rx_data_cleared", rx_data, 8'h00);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        check("abort_no_rx", rx_cnt - r0, 0);
        check("abort_no_done", done_cnt - d0, 0);

        txb[0] = 8'h81;
        exp_rx.push_back(8'h81);
        run_txn(1, -1, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
